// File: rtl/io_frame_sequencer_if.sv
// Bus bundle between io_frame_sequencer and its frame-timing logic, I/O bus and sample memory.
// master = sequencer side, slave = environment side.
interface io_frame_sequencer_if #(
  parameter int SAMPLE_WIDTH      = 36,
  parameter int SAMPLE_ADDR_WIDTH = 10,
  parameter int IO_WIDTH          = 24,
  parameter int IO_ADDR_WIDTH     = 10
);
  logic                         frame_start;
  logic                         overrun_clr;
  logic                         busy;
  logic                         core_hold;
  logic                         done;
  logic                         overrun;
  logic [IO_ADDR_WIDTH-1:0]     io_rd_addr;
  logic                         io_rd_en;
  logic [IO_WIDTH-1:0]          io_rd_data;
  logic [IO_ADDR_WIDTH-1:0]     io_wr_addr;
  logic                         io_wr_en;
  logic [IO_WIDTH-1:0]          io_wr_data;
  logic [SAMPLE_ADDR_WIDTH-1:0] sample_rd_addr;
  logic                         sample_rd_en;
  logic [SAMPLE_WIDTH-1:0]      sample_rd_data;
  logic [SAMPLE_ADDR_WIDTH-1:0] sample_wr_addr;
  logic                         sample_wr_en;
  logic [SAMPLE_WIDTH-1:0]      sample_wr_data;

  modport master (
    input  frame_start, overrun_clr, io_rd_data, sample_rd_data,
    output busy, core_hold, done, overrun,
    output io_rd_addr, io_rd_en, io_wr_addr, io_wr_en, io_wr_data,
    output sample_rd_addr, sample_rd_en, sample_wr_addr, sample_wr_en, sample_wr_data
  );

  modport slave (
    output frame_start, overrun_clr, io_rd_data, sample_rd_data,
    input  busy, core_hold, done, overrun,
    input  io_rd_addr, io_rd_en, io_wr_addr, io_wr_en, io_wr_data,
    input  sample_rd_addr, sample_rd_en, sample_wr_addr, sample_wr_en, sample_wr_data
  );
endinterface

// File: rtl/io_frame_sequencer.sv
// Per-frame copier: physical inputs -> sample memory, then sample memory -> physical outputs.
// Optional macro IO_SEQ_SATURATE_EN clamps outputs to the signed I/O range instead of truncating.
module io_frame_sequencer #(
  parameter int SAMPLE_WIDTH         = 36,
  parameter int SAMPLE_ADDR_WIDTH    = 10,
  parameter int IO_WIDTH             = 24,
  parameter int IO_ADDR_WIDTH        = 10,
  parameter int PHYSICAL_IO_PER_CORE = 8,
  parameter int INPUT_BASE           = 0,
  parameter int OUTPUT_BASE          = 8
) (
  input logic                  clk,
  input logic                  reset,
  io_frame_sequencer_if.master bus
);
  localparam int N  = PHYSICAL_IO_PER_CORE;
  localparam int KW = $clog2(N + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N);

  typedef enum logic [1:0] {IDLE, IN, OUT, DONE} state_e;

  state_e                       state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic [KW-1:0]                rd_idx_q, rd_idx_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         overrun_q, overrun_d;
  logic                         io_rd_en_q, io_rd_en_d;
  logic [IO_ADDR_WIDTH-1:0]     io_rd_addr_q, io_rd_addr_d;
  logic                         sample_wr_en_q, sample_wr_en_d;
  logic [SAMPLE_ADDR_WIDTH-1:0] sample_wr_addr_q, sample_wr_addr_d;
  logic                         sample_rd_en_q, sample_rd_en_d;
  logic [SAMPLE_ADDR_WIDTH-1:0] sample_rd_addr_q, sample_rd_addr_d;
  logic                         io_wr_en_q, io_wr_en_d;
  logic [IO_ADDR_WIDTH-1:0]     io_wr_addr_q, io_wr_addr_d;
  logic signed [SAMPLE_WIDTH-1:0] sample_wr_data_d, sample_wr_hold_q;
  logic signed [IO_WIDTH-1:0]     io_wr_data_d, io_wr_hold_q;

  function automatic logic signed [SAMPLE_WIDTH-1:0] sign_extend(
    input logic signed [IO_WIDTH-1:0] x
  );
    return {{(SAMPLE_WIDTH-IO_WIDTH){x[IO_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [IO_WIDTH-1:0] to_io(
    input logic signed [SAMPLE_WIDTH-1:0] s
  );
`ifdef IO_SEQ_SATURATE_EN
    logic [SAMPLE_WIDTH-IO_WIDTH:0] top;
    top = s[SAMPLE_WIDTH-1:IO_WIDTH-1];
    // In range exactly when every bit above the IO sign bit copies it.
    if ((top == '0) || (top == '1)) return IO_WIDTH'(s);
    else if (s[SAMPLE_WIDTH-1])     return {1'b1, {(IO_WIDTH-1){1'b0}}};
    else                            return {1'b0, {(IO_WIDTH-1){1'b1}}};
`else
    return IO_WIDTH'(s);
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.frame_start) begin
          state_d = IN;
          k_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      IN: begin
        if (k_q == K_LAST) begin
          state_d = OUT;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      OUT: begin
        if (k_q == K_LAST) state_d = DONE;
        else               k_d = k_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Each phase spends its last slot (k == N) draining the final write.
    busy_d = (state_d == IN) || (state_d == OUT);
    done_d = (state_d == DONE);

    overrun_d = overrun_q;
    if (bus.overrun_clr)            overrun_d = 1'b0;
    if (bus.frame_start && busy_q)  overrun_d = 1'b1;

    io_rd_en_d   = (state_d == IN) && (k_d != K_LAST);
    io_rd_addr_d = io_rd_en_d ? IO_ADDR_WIDTH'(k_d) : io_rd_addr_q;

    sample_rd_en_d   = (state_d == OUT) && (k_d != K_LAST);
    sample_rd_addr_d = sample_rd_en_d ? SAMPLE_ADDR_WIDTH'(OUTPUT_BASE + int'(k_d))
                                      : sample_rd_addr_q;
    rd_idx_d         = sample_rd_en_d ? k_d : rd_idx_q;

    sample_wr_en_d   = io_rd_en_q;
    sample_wr_addr_d = io_rd_en_q ? SAMPLE_ADDR_WIDTH'(INPUT_BASE + int'(io_rd_addr_q))
                                  : sample_wr_addr_q;

    io_wr_en_d   = sample_rd_en_q;
    io_wr_addr_d = sample_rd_en_q ? IO_ADDR_WIDTH'(rd_idx_q) : io_wr_addr_q;

    // Read data arrives one cycle after the strobe; hold the last value otherwise.
    sample_wr_data_d = sample_wr_en_q ? sign_extend(bus.io_rd_data) : sample_wr_hold_q;
    io_wr_data_d     = io_wr_en_q ? to_io(bus.sample_rd_data) : io_wr_hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      k_q              <= '0;
      rd_idx_q         <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      overrun_q        <= 1'b0;
      io_rd_en_q       <= 1'b0;
      io_rd_addr_q     <= '0;
      sample_wr_en_q   <= 1'b0;
      sample_wr_addr_q <= '0;
      sample_rd_en_q   <= 1'b0;
      sample_rd_addr_q <= '0;
      io_wr_en_q       <= 1'b0;
      io_wr_addr_q     <= '0;
      sample_wr_hold_q <= '0;
      io_wr_hold_q     <= '0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      rd_idx_q         <= rd_idx_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      overrun_q        <= overrun_d;
      io_rd_en_q       <= io_rd_en_d;
      io_rd_addr_q     <= io_rd_addr_d;
      sample_wr_en_q   <= sample_wr_en_d;
      sample_wr_addr_q <= sample_wr_addr_d;
      sample_rd_en_q   <= sample_rd_en_d;
      sample_rd_addr_q <= sample_rd_addr_d;
      io_wr_en_q       <= io_wr_en_d;
      io_wr_addr_q     <= io_wr_addr_d;
      sample_wr_hold_q <= sample_wr_data_d;
      io_wr_hold_q     <= io_wr_data_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.core_hold      = busy_q;
  assign bus.done           = done_q;
  assign bus.overrun        = overrun_q;
  assign bus.io_rd_en       = io_rd_en_q;
  assign bus.io_rd_addr     = io_rd_addr_q;
  assign bus.sample_wr_en   = sample_wr_en_q;
  assign bus.sample_wr_addr = sample_wr_addr_q;
  assign bus.sample_wr_data = sample_wr_data_d;
  assign bus.sample_rd_en   = sample_rd_en_q;
  assign bus.sample_rd_addr = sample_rd_addr_q;
  assign bus.io_wr_en       = io_wr_en_q;
  assign bus.io_wr_addr     = io_wr_addr_q;
  assign bus.io_wr_data     = io_wr_data_d;
endmodule

// File: tb/tb_io_frame_sequencer.sv
// Directed bench for io_frame_sequencer with simple I/O and sample memory models.
// Saturation expectations follow IO_SEQ_SATURATE_EN.
module tb_io_frame_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  io_frame_sequencer_if bif ();

  io_frame_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  logic [23:0] io_in   [8];
  logic [23:0] io_out  [8];
  logic [35:0] rd_mem  [1024];
  logic [35:0] dst_mem [1024];

  always @(posedge clk) begin
    if (bif.io_rd_en)     bif.io_rd_data     <= io_in[bif.io_rd_addr[2:0]];
    if (bif.sample_rd_en) bif.sample_rd_data <= rd_mem[bif.sample_rd_addr];
    if (bif.sample_wr_en) dst_mem[bif.sample_wr_addr] <= bif.sample_wr_data;
    if (bif.io_wr_en)     io_out[bif.io_wr_addr[2:0]] <= bif.io_wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {bif.io_rd_en, bif.sample_wr_en, bif.sample_rd_en, bif.io_wr_en,
            bif.busy, bif.core_hold, bif.done};
  endfunction

  logic [35:0] exp_in [8];
  logic [23:0] exp_o0, exp_o1;
  int rd_cnt, done_cnt, done_at;

  initial begin
    exp_in = '{36'h000000000, 36'h000000100, 36'h000000200, 36'hFFF800000,
               36'h000000400, 36'h000000500, 36'h000000600, 36'h000000700};
`ifdef IO_SEQ_SATURATE_EN
    exp_o0 = 24'h7FFFFF;
    exp_o1 = 24'h800000;
`else
    exp_o0 = 24'hFFFFFF;
    exp_o1 = 24'h000000;
`endif
    for (int k = 0; k < 8; k++) begin
      io_in[k]      = 24'(24'h000100 * k);
      rd_mem[8 + k] = 36'(k);
    end
    io_in[3] = 24'h800000;

    // Reset: three cycles high, then ten idle cycles with everything at zero.
    reset = 1'b1;
    bif.frame_start = 1'b0;
    bif.overrun_clr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("reset_outputs c%0d", i),
          {bif.busy, bif.core_hold, bif.done, bif.overrun, bif.io_rd_en, bif.io_wr_en,
           bif.sample_rd_en, bif.sample_wr_en, bif.io_rd_addr, bif.io_wr_addr,
           bif.io_wr_data, bif.sample_rd_addr, bif.sample_wr_addr, bif.sample_wr_data},
          128'd0);
      tick();
    end

    // Single frame with the full cycle schedule.
    bif.frame_start = 1'b1;
    tick();
    bif.frame_start = 1'b0;
    for (int t = 1; t <= 19; t++) begin
      chk($sformatf("sched t=%0d", t), strobes(),
          {(t >= 1 && t <= 8), (t >= 2 && t <= 9), (t >= 10 && t <= 17),
           (t >= 11 && t <= 18), (t <= 18), (t <= 18), (t == 19)});
      if (t >= 1 && t <= 8)   chk($sformatf("io_rd_addr t=%0d", t), bif.io_rd_addr, 10'(t - 1));
      if (t >= 2 && t <= 9) begin
        chk($sformatf("sample_wr_addr t=%0d", t), bif.sample_wr_addr, 10'(t - 2));
        chk($sformatf("sample_wr_data t=%0d", t), bif.sample_wr_data, exp_in[t - 2]);
      end
      if (t >= 10 && t <= 17) chk($sformatf("sample_rd_addr t=%0d", t), bif.sample_rd_addr, 10'(t - 2));
      if (t >= 11 && t <= 18) begin
        chk($sformatf("io_wr_addr t=%0d", t), bif.io_wr_addr, 10'(t - 11));
        chk($sformatf("io_wr_data t=%0d", t), bif.io_wr_data, 24'(t - 11));
      end
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("frame1 smem[%0d]", k), dst_mem[k], exp_in[k]);
      chk($sformatf("frame1 out[%0d]", k), io_out[k], 24'(k));
    end
    chk("frame1 overrun", bif.overrun, 1'b0);

    // Output conversion of out-of-range samples.
    rd_mem[8] = 36'h07FFFFFFF;
    rd_mem[9] = 36'hF80000000;
    bif.frame_start = 1'b1;
    tick();
    bif.frame_start = 1'b0;
    repeat (19) tick();
    chk("conv out[0]", io_out[0], exp_o0);
    chk("conv out[1]", io_out[1], exp_o1);
    chk("conv out[2]", io_out[2], 24'h000002);

    // Overrun: second strobe at cycle 5 ignored, cleared at cycle 25.
    rd_cnt = 0;
    done_cnt = 0;
    bif.frame_start = 1'b1;
    tick();
    for (int t = 1; t <= 26; t++) begin
      bif.frame_start = (t == 5);
      bif.overrun_clr = (t == 25);
      chk($sformatf("overrun t=%0d", t), bif.overrun, (t >= 6 && t <= 25));
      if (bif.io_rd_en) rd_cnt++;
      if (bif.done) done_cnt++;
      tick();
    end
    bif.frame_start = 1'b0;
    bif.overrun_clr = 1'b0;
    chk("overrun rd count", rd_cnt, 8);
    chk("overrun done count", done_cnt, 1);

    // Set beats clear in the same cycle.
    bif.frame_start = 1'b1;
    tick();
    bif.frame_start = 1'b0;
    repeat (2) tick();
    bif.frame_start = 1'b1;
    bif.overrun_clr = 1'b1;
    tick();
    bif.frame_start = 1'b0;
    bif.overrun_clr = 1'b0;
    chk("set_wins overrun", bif.overrun, 1'b1);
    bif.overrun_clr = 1'b1;
    tick();
    bif.overrun_clr = 1'b0;
    chk("clear overrun", bif.overrun, 1'b0);
    repeat (16) tick();

    // Back-to-back: next strobe on the done cycle.
    bif.frame_start = 1'b1;
    tick();
    bif.frame_start = 1'b0;
    repeat (18) tick();
    chk("b2b done c19", bif.done, 1'b1);
    bif.frame_start = 1'b1;
    tick();
    bif.frame_start = 1'b0;
    chk("b2b io_rd_en c20", {bif.io_rd_en, bif.busy, bif.io_rd_addr}, {1'b1, 1'b1, 10'd0});
    done_at = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bif.done && done_at < 0) done_at = i;
    end
    chk("b2b second done", done_at, 18);
    chk("b2b overrun", bif.overrun, 1'b0);

    // Reset mid-frame, then a clean full frame with fresh inputs.
    for (int k = 0; k < 8; k++) io_in[k] = 24'(24'h000A00 + k);
    bif.frame_start = 1'b1;
    tick();
    bif.frame_start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset strobes c5", strobes(), 7'd0);
    repeat (10) tick();
    chk("midreset no late write", dst_mem[3], 36'hFFF800000);
    bif.frame_start = 1'b1;
    tick();
    bif.frame_start = 1'b0;
    done_at = -1;
    for (int t = 1; t <= 20; t++) begin
      if (bif.done && done_at < 0) done_at = t;
      tick();
    end
    chk("post_reset done cycle", done_at, 19);
    for (int k = 0; k < 8; k++)
      chk($sformatf("post_reset smem[%0d]", k), dst_mem[k], 36'(36'h000000A00 + k));
    chk("post_reset out[3]", io_out[3], 24'h000003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
